// File: rtl/universal_register.sv
// WIDTH-bit register with hold/load/shift/rotate/count modes, clock enable and sync reset.
// Optional carry-out pulse on counter wrap is enabled by defining UREG_CARRY_EN.
module universal_register #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             C,
   input  logic             nR,
   input  logic             EN,
   input  logic [2:0]       M,
   input  logic [WIDTH-1:0] D,
   input  logic             SL,
   input  logic             SR,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] nQ,
   output logic             SO,
`ifdef UREG_CARRY_EN
   output logic             CO,
`endif
   output logic             Z
);

   typedef enum logic [2:0] {
      ModeHold  = 3'b000,
      ModeLoad  = 3'b001,
      ModeShl   = 3'b010,
      ModeShr   = 3'b011,
      ModeRol   = 3'b100,
      ModeRor   = 3'b101,
      ModeCntUp = 3'b110,
      ModeCntDn = 3'b111
   } mode_e;

   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   logic [WIDTH-1:0] q_d, q_q;
   logic             so_d, so_q;
   logic [WIDTH-1:0] shl_val, shr_val, rol_val, ror_val;

   // A one-bit register has no neighbour bits: shifts take the serial input, rotates are no-ops.
   if (WIDTH == 1) begin : g_w1
      assign shl_val = SL;
      assign shr_val = SR;
      assign rol_val = q_q;
      assign ror_val = q_q;
   end else begin : g_wn
      assign shl_val = {q_q[WIDTH-2:0], SL};
      assign shr_val = {SR, q_q[WIDTH-1:1]};
      assign rol_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      assign ror_val = {q_q[0], q_q[WIDTH-1:1]};
   end

`ifdef UREG_CARRY_EN
   logic co_d, co_q;
`endif

   always_comb begin
      q_d  = q_q;
      so_d = so_q;
`ifdef UREG_CARRY_EN
      co_d = 1'b0;
`endif
      if (EN) begin
         unique case (mode_e'(M))
            ModeHold: ;
            ModeLoad: q_d = D;
            ModeShl: begin
               q_d  = shl_val;
               so_d = q_q[WIDTH-1];
            end
            ModeShr: begin
               q_d  = shr_val;
               so_d = q_q[0];
            end
            ModeRol: begin
               q_d  = rol_val;
               so_d = q_q[WIDTH-1];
            end
            ModeRor: begin
               q_d  = ror_val;
               so_d = q_q[0];
            end
            ModeCntUp: begin
               q_d = q_q + One;
`ifdef UREG_CARRY_EN
               co_d = &q_q;
`endif
            end
            ModeCntDn: begin
               q_d = q_q - One;
`ifdef UREG_CARRY_EN
               co_d = ~|q_q;
`endif
            end
         endcase
      end
   end

   always_ff @(posedge C) begin
      if (!nR) begin
         q_q  <= RESET_VALUE;
         so_q <= 1'b0;
`ifdef UREG_CARRY_EN
         co_q <= 1'b0;
`endif
      end else begin
         q_q  <= q_d;
         so_q <= so_d;
`ifdef UREG_CARRY_EN
         co_q <= co_d;
`endif
      end
   end

   assign Q  = q_q;
   assign nQ = ~q_q;
   assign SO = so_q;
   assign Z  = (q_q == '0);
`ifdef UREG_CARRY_EN
   assign CO = co_q;
`endif

endmodule

// File: tb/tb_universal_register.sv
// Self-checking bench for universal_register: directed vector table plus a random model run.
// Checks CO as well when UREG_CARRY_EN is defined.
module tb_universal_register;

   typedef struct {
      logic       nr;
      logic       en;
      logic [2:0] m;
      logic [7:0] d;
      logic       sl;
      logic       sr;
      logic [7:0] q;
      logic       so;
      logic       co;
   } vec_t;

   typedef struct {
      logic [7:0] q;
      logic       so;
      logic       co;
      logic       chk_b;
   } exp_t;

   logic       clk = 1'b0;
   logic       nR = 1'b0, EN = 1'b0, SL = 1'b0, SR = 1'b0;
   logic [2:0] M = 3'b000;
   logic [7:0] D = 8'h00;
   logic [7:0] q_a, nq_a, q_b, nq_b;
   logic       so_a, z_a, so_b, z_b;
`ifdef UREG_CARRY_EN
   logic       co_a, co_b;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   universal_register #(.WIDTH(8), .RESET_VALUE(8'h00)) u_dut_a (
      .C(clk), .nR(nR), .EN(EN), .M(M), .D(D), .SL(SL), .SR(SR),
      .Q(q_a), .nQ(nq_a), .SO(so_a),
`ifdef UREG_CARRY_EN
      .CO(co_a),
`endif
      .Z(z_a)
   );

   universal_register #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut_b (
      .C(clk), .nR(nR), .EN(EN), .M(M), .D(D), .SL(SL), .SR(SR),
      .Q(q_b), .nQ(nq_b), .SO(so_b),
`ifdef UREG_CARRY_EN
      .CO(co_b),
`endif
      .Z(z_b)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic nr, input logic en, input logic [2:0] m,
                               input logic [7:0] d, input logic sl, input logic sr,
                               input logic [7:0] q, input logic so, input logic co);
      vec_t v;
      v.nr = nr; v.en = en; v.m = m; v.d = d; v.sl = sl; v.sr = sr;
      v.q = q; v.so = so; v.co = co;
      return v;
   endfunction

   // Drive one edge's worth of inputs and queue what the DUT must show after that edge.
   task automatic drive(input vec_t v);
      exp_t e;
      @(posedge clk);
      #2;
      nR = v.nr; EN = v.en; M = v.m; D = v.d; SL = v.sl; SR = v.sr;
      e.q = v.q; e.so = v.so; e.co = v.co; e.chk_b = ~v.nr;
      sb_q.push_back(e);
   endtask

   // Monitor: compare one queued expectation 1 time unit after each rising edge.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("q", q_a, e.q);
         check("nq", nq_a, ~e.q);
         check("z", {7'd0, z_a}, {7'd0, e.q == 8'h00});
         check("so", {7'd0, so_a}, {7'd0, e.so});
`ifdef UREG_CARRY_EN
         check("co", {7'd0, co_a}, {7'd0, e.co});
`endif
         if (e.chk_b) begin
            check("rv_q", q_b, 8'hA5);
            check("rv_nq", nq_b, 8'h5A);
            check("rv_z", {7'd0, z_b}, 8'h00);
            check("rv_so", {7'd0, so_b}, 8'h00);
         end
      end
   end

   initial begin
      logic [7:0] mq, nq;
      logic       mso, nso, nco;
      vec_t       v;

      //             nr  en  m       d      sl  sr  q      so  co
      tbl.push_back(mk(0, 1, 3'b001, 8'hFF, 0, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 1, 3'b001, 8'hFF, 0, 0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 1, 3'b001, 8'hB4, 0, 0, 8'hB4, 0, 0));
      tbl.push_back(mk(1, 0, 3'b110, 8'h00, 0, 0, 8'hB4, 0, 0));
      tbl.push_back(mk(1, 0, 3'b110, 8'h00, 0, 0, 8'hB4, 0, 0));
      tbl.push_back(mk(1, 0, 3'b110, 8'h00, 0, 0, 8'hB4, 0, 0));
      tbl.push_back(mk(1, 1, 3'b001, 8'h81, 0, 0, 8'h81, 0, 0));
      tbl.push_back(mk(1, 1, 3'b010, 8'h00, 1, 0, 8'h03, 1, 0));
      tbl.push_back(mk(1, 1, 3'b001, 8'h81, 0, 0, 8'h81, 1, 0));
      tbl.push_back(mk(1, 1, 3'b011, 8'h00, 0, 0, 8'h40, 1, 0));
      tbl.push_back(mk(1, 1, 3'b011, 8'h00, 0, 1, 8'hA0, 0, 0));
      tbl.push_back(mk(1, 1, 3'b001, 8'h81, 0, 0, 8'h81, 0, 0));
      tbl.push_back(mk(1, 1, 3'b100, 8'h00, 0, 0, 8'h03, 1, 0));
      tbl.push_back(mk(1, 1, 3'b001, 8'h81, 0, 0, 8'h81, 1, 0));
      tbl.push_back(mk(1, 1, 3'b101, 8'h00, 0, 0, 8'hC0, 1, 0));
      tbl.push_back(mk(1, 1, 3'b001, 8'h5A, 0, 0, 8'h5A, 1, 0));
      tbl.push_back(mk(1, 1, 3'b100, 8'h00, 0, 0, 8'hB4, 0, 0));
      tbl.push_back(mk(1, 1, 3'b100, 8'h00, 0, 0, 8'h69, 1, 0));
      tbl.push_back(mk(1, 1, 3'b100, 8'h00, 0, 0, 8'hD2, 0, 0));
      tbl.push_back(mk(1, 1, 3'b100, 8'h00, 0, 0, 8'hA5, 1, 0));
      tbl.push_back(mk(1, 1, 3'b100, 8'h00, 0, 0, 8'h4B, 1, 0));
      tbl.push_back(mk(1, 1, 3'b100, 8'h00, 0, 0, 8'h96, 0, 0));
      tbl.push_back(mk(1, 1, 3'b100, 8'h00, 0, 0, 8'h2D, 1, 0));
      tbl.push_back(mk(1, 1, 3'b100, 8'h00, 0, 0, 8'h5A, 0, 0));
      tbl.push_back(mk(1, 1, 3'b001, 8'hFE, 0, 0, 8'hFE, 0, 0));
      tbl.push_back(mk(1, 1, 3'b110, 8'h00, 0, 0, 8'hFF, 0, 0));
      tbl.push_back(mk(1, 1, 3'b110, 8'h00, 0, 0, 8'h00, 0, 1));
      tbl.push_back(mk(1, 1, 3'b110, 8'h00, 0, 0, 8'h01, 0, 0));
      tbl.push_back(mk(1, 1, 3'b001, 8'h00, 0, 0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 1, 3'b111, 8'h00, 0, 0, 8'hFF, 0, 1));
      tbl.push_back(mk(1, 1, 3'b111, 8'h00, 0, 0, 8'hFE, 0, 0));

      foreach (tbl[i]) drive(tbl[i]);
      tbl.delete();

      // Reset mid-count: SO is set first so the clear is observable.
      tbl.push_back(mk(1, 1, 3'b001, 8'h81, 0, 0, 8'h81, 0, 0));
      tbl.push_back(mk(1, 1, 3'b010, 8'h00, 0, 0, 8'h02, 1, 0));
      tbl.push_back(mk(1, 1, 3'b001, 8'h36, 0, 0, 8'h36, 1, 0));
      tbl.push_back(mk(1, 1, 3'b110, 8'h00, 0, 0, 8'h37, 1, 0));
      tbl.push_back(mk(0, 1, 3'b110, 8'h00, 0, 0, 8'h00, 0, 0));
      tbl.push_back(mk(1, 1, 3'b110, 8'h00, 0, 0, 8'h01, 0, 0));
      // Reset on an edge that would otherwise wrap and pulse CO.
      tbl.push_back(mk(1, 1, 3'b001, 8'hFF, 0, 0, 8'hFF, 0, 0));
      tbl.push_back(mk(0, 1, 3'b110, 8'h00, 0, 0, 8'h00, 0, 0));
      // Reset wins over EN=0.
      tbl.push_back(mk(1, 1, 3'b001, 8'h55, 0, 0, 8'h55, 0, 0));
      tbl.push_back(mk(0, 0, 3'b001, 8'hAA, 0, 0, 8'h00, 0, 0));
      foreach (tbl[i]) drive(tbl[i]);

      mq = 8'h00;
      mso = 1'b0;
      for (int i = 0; i < 300; i++) begin
         v = mk(($urandom_range(0, 15) != 0), ($urandom_range(0, 5) != 0),
                3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'h00, 0, 0);
         nq = mq;
         nso = mso;
         nco = 1'b0;
         if (!v.nr) begin
            nq = 8'h00;
            nso = 1'b0;
         end else if (v.en) begin
            case (v.m)
               3'd1: nq = v.d;
               3'd2: begin nq = {mq[6:0], v.sl}; nso = mq[7]; end
               3'd3: begin nq = {v.sr, mq[7:1]}; nso = mq[0]; end
               3'd4: begin nq = {mq[6:0], mq[7]}; nso = mq[7]; end
               3'd5: begin nq = {mq[0], mq[7:1]}; nso = mq[0]; end
               3'd6: begin nq = mq + 8'd1; nco = (mq == 8'hFF); end
               3'd7: begin nq = mq - 8'd1; nco = (mq == 8'h00); end
               default: ;
            endcase
         end
         v.q = nq;
         v.so = nso;
         v.co = nco;
         drive(v);
         mq = nq;
         mso = nso;
      end

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
      #3;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
